// File: rtl/add_reducer_pkg.sv
// Shared elaboration helpers for the add_reducer adder tree.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package add_reducer_pkg;

    // Number of pairwise levels needed to reduce 'addends' words to one.
    function automatic int tree_levels(input int addends);
        return $clog2(addends);
    endfunction

    // True for powers of two that are at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // Word offset of a level's outputs in the flattened node vector.
    // Level 0 is the raw addends at offset 0, level 1 follows at offset
    // 'addends', and so on, halving each time. The final single word
    // lands at 2*addends-2.
    function automatic int node_offset(input int addends, input int level);
        return 2 * addends - 2 * (addends >> level);
    endfunction

endpackage

// File: rtl/add_reducer_level.sv
// One adder-tree level: out word j = in word 2j + in word 2j+1, truncated to WORD_WIDTH.
// Latency: 1 cycle (registered output, synchronous active-low reset to 0).
// Backpressure: none; new operands are accepted on every rising edge.
module add_reducer_level #(
    parameter int WORD_WIDTH = 36,
    parameter int INPUTS     = 8
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [INPUTS*WORD_WIDTH-1:0]        in_dat,
    output logic [(INPUTS/2)*WORD_WIDTH-1:0]    out_dat
);

    localparam int OUTPUTS = INPUTS / 2;

    // Register the pairwise sums; carries beyond WORD_WIDTH are dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_dat <= '0;
        end else begin
            for (int j = 0; j < OUTPUTS; j++) begin
                out_dat[j*WORD_WIDTH +: WORD_WIDTH] <=
                    in_dat[(2*j)*WORD_WIDTH +: WORD_WIDTH] +
                    in_dat[(2*j+1)*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/add_reducer.sv
// Pipelined adder tree: sums ADDENDS unsigned words modulo 2^WORD_WIDTH.
// Latency: log2(ADDENDS) cycles (3 for 8 addends), one result per cycle.
// Backpressure: none; the pipeline advances on every rising edge out of reset.
module add_reducer
    import add_reducer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int ADDENDS    = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [ADDENDS*WORD_WIDTH-1:0]   addends,
    output logic [WORD_WIDTH-1:0]           reduction
);

    localparam int LEVELS = tree_levels(ADDENDS);
    localparam int NODES  = 2 * ADDENDS - 1;

    if (!is_pow2(ADDENDS)) begin : g_bad_addends
        $error("add_reducer: ADDENDS must be a power of two, at least 2");
    end

    // Every level's outputs live in one flat vector: raw addends first,
    // then each level's registered sums, ending in the single final word.
    wire [NODES*WORD_WIDTH-1:0] nodes;

    // No input register: the first level samples addends directly.
    assign nodes[ADDENDS*WORD_WIDTH-1:0] = addends;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int INPUTS = ADDENDS >> (k - 1);
        localparam int IN_LO  = node_offset(ADDENDS, k - 1) * WORD_WIDTH;
        localparam int OUT_LO = node_offset(ADDENDS, k) * WORD_WIDTH;

        add_reducer_level #(
            .WORD_WIDTH (WORD_WIDTH),
            .INPUTS     (INPUTS)
        ) u_level (
            .clock   (clock),
            .reset_n (reset_n),
            .in_dat  (nodes[IN_LO +: INPUTS*WORD_WIDTH]),
            .out_dat (nodes[OUT_LO +: (INPUTS/2)*WORD_WIDTH])
        );
    end

    // The final level's register drives the result directly.
    assign reduction = nodes[(NODES-1)*WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: tb/tb_add_reducer.sv
// Self-checking bench for add_reducer: planned stimulus, queued expectations, negedge monitor.
// Latency: expects each sum 3 edges after the edge that samples it.
// Backpressure: none; one stimulus step per clock cycle.
`timescale 1ns/1ps
module tb_add_reducer;

    localparam int W   = 36;
    localparam int A   = 8;
    localparam int LAT = 3;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [A*W-1:0]   addends = '0;
    logic [W-1:0]     reduction;

    add_reducer #(
        .WORD_WIDTH (W),
        .ADDENDS    (A)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .addends   (addends),
        .reduction (reduction)
    );

    always #5 clock = ~clock;

    // Count rising edges so the monitor knows which result is due.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [W-1:0] val;
        int           step;
    } exp_t;

    exp_t           exp_q[$];
    logic [A*W-1:0] plan_bus[$];
    bit             plan_rst[$];

    int checks = 0;
    int fails  = 0;

    // Reference: plain integer sum of all words, then reduced mod 2^W.
    function automatic logic [W-1:0] ref_sum(input logic [A*W-1:0] bus);
        logic [63:0] acc;
        acc = 64'd0;
        for (int i = 0; i < A; i++)
            acc = acc + {{(64-W){1'b0}}, bus[i*W +: W]};
        return acc[W-1:0];
    endfunction

    // Directed patterns: 0 zeros, 1 ones, 2 word i = i, 3 word i = i+1,
    // 4 all max, 5 max in word 0 and 1 in word 1.
    function automatic logic [A*W-1:0] pattern(input int kind);
        logic [A*W-1:0] bus;
        logic [W-1:0]   w;
        bus = '0;
        for (int i = 0; i < A; i++) begin
            case (kind)
                0:       w = '0;
                1:       w = W'(1);
                2:       w = W'(i);
                3:       w = W'(i + 1);
                4:       w = '1;
                default: begin
                    if (i == 0)      w = '1;
                    else if (i == 1) w = W'(1);
                    else             w = '0;
                end
            endcase
            bus[i*W +: W] = w;
        end
        return bus;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [31:0] lo;
        logic [31:0] hi;
        lo = $urandom;
        hi = $urandom;
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return W'(lo[7:0]);
            default: return {hi[W-33:0], lo};
        endcase
    endfunction

    function automatic logic [A*W-1:0] rand_bus();
        logic [A*W-1:0] bus;
        for (int i = 0; i < A; i++) bus[i*W +: W] = rand_word();
        return bus;
    endfunction

    task automatic add_step(input logic [A*W-1:0] bus, input bit rst);
        plan_bus.push_back(bus);
        plan_rst.push_back(rst);
    endtask

    // The sum sampled at step n survives only if no reset hits any of the
    // LAT edges it spends in the tree; otherwise the output slot reads 0.
    function automatic logic [W-1:0] expected_at(input int n);
        for (int k = n; k < n + LAT && k < plan_rst.size(); k++)
            if (plan_rst[k]) return '0;
        return ref_sum(plan_bus[n]);
    endfunction

    task automatic build_plan();
        for (int i = 0; i < 3; i++) add_step(pattern(0), 1'b1);
        // Each directed pattern held long enough to reach the output.
        for (int kind = 0; kind <= 5; kind++)
            for (int i = 0; i < 4; i++) add_step(pattern(kind), 1'b0);
        // Back-to-back patterns changing every cycle.
        for (int kind = 0; kind <= 3; kind++) add_step(pattern(kind), 1'b0);
        // Single-cycle reset mid-stream with all-ones inputs.
        for (int i = 0; i < 5; i++) add_step(pattern(1), 1'b0);
        add_step(pattern(1), 1'b1);
        for (int i = 0; i < 5; i++) add_step(pattern(1), 1'b0);
        // Reset held for several cycles.
        for (int i = 0; i < 4; i++) add_step(pattern(3), 1'b1);
        for (int i = 0; i < 4; i++) add_step(pattern(3), 1'b0);
        // Random stream with occasional short resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                int len;
                len = $urandom_range(1, 3);
                for (int r = 0; r < len; r++) add_step(rand_bus(), 1'b1);
            end else begin
                add_step(rand_bus(), 1'b0);
            end
        end
        for (int i = 0; i < LAT; i++) add_step(pattern(0), 1'b0);
    endtask

    // Driver: one planned step per cycle, expectation queued as it is issued.
    initial begin
        build_plan();
        for (int n = 0; n < plan_bus.size(); n++) begin
            @(negedge clock);
            addends = plan_bus[n];
            reset_n = !plan_rst[n];
            exp_q.push_back('{due: cyc + LAT, val: expected_at(n), step: n});
        end
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(negedge clock);
            #1;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL expired wait: %0d expected sums never checked (first step %0d)",
                     exp_q.size(), exp_q[0].step);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Monitor: compare the due result on the falling edge, away from sampling.
    exp_t mon_e;
    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e  = exp_q.pop_front();
            checks = checks + 1;
            if (mon_e.due != cyc || reduction !== mon_e.val) begin
                fails = fails + 1;
                $display("FAIL sum step %0d (cycle %0d, due %0d): reduction=%h required=%h",
                         mon_e.step, cyc, mon_e.due, reduction, mon_e.val);
            end
        end
    end

    // Reset-state check: after any rising edge with reset_n low, reduction reads 0, never X.
    bit rst_edge = 1'b0;
    always @(posedge clock) rst_edge <= !reset_n;

    always @(negedge clock) begin
        if (rst_edge) begin
            checks = checks + 1;
            if (reduction !== '0) begin
                fails = fails + 1;
                $display("FAIL reset state (cycle %0d): reduction=%h required=0",
                         cyc, reduction);
            end
        end
    end

endmodule
